block_gather: RTL and testbench
===============================

# block_gather

Raster-to-block gatherer placed directly upstream of the DCT level-shift stage. It accepts one pixel sample per valid cycle in row-major order. It assembles 64 samples into an 8x8 block and presents the whole block on a registered array with a single-cycle valid pulse, which is the format the level-shift stage consumes. Block realignment, drop reporting and a completed-block counter are included for frame bring-up and debug.

## Interface
- COUNT_WIDTH, 16, width of the completed-block counter.
- CLOCK  in  1  system clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-low reset.
- input_valid  in  1  INPUT_DATA and input_first are valid this cycle.
- input_first  in  1  marks the sample as index 0 of a new block; qualified by input_valid.
- INPUT_DATA  in  32  pixel sample, unsigned, nominal range 0..1023.
- output_valid  out  1  one-cycle pulse: OUTPUT_DATA holds a newly completed block.
- OUTPUT_DATA  out  32 x [8][8]  assembled block, [row][col].
- output_drop  out  1  one-cycle pulse: a partial block was discarded by input_first.
- block_count  out  COUNT_WIDTH  number of completed blocks, modulo 2^COUNT_WIDTH.

## Operation
- Sample index idx (6 bits) is 0 after reset. An accepted sample (input_valid=1) is written to buf[idx[5:3]][idx[2:0]].
- Counter states:
  - EMPTY: idx==0.
  - FILL: idx 1..63.
- Accepted sample with input_first=1: written at index 0, idx becomes 1.
  - From FILL, output_drop pulses on the next cycle and the partial block is lost.
  - From EMPTY, no drop is reported.
  - input_first with input_valid=0 is ignored.
- Accepted sample at idx==63 (and input_first=0): completes the block.
  - OUTPUT_DATA is loaded from buf, with element [7][7] taken directly from the incoming sample.
  - output_valid pulses.
  - block_count increments and wraps at 2^COUNT_WIDTH.
  - idx returns to 0.
- input_first arriving on what would be the 64th sample takes priority: the block is dropped, nothing is completed, idx becomes 1.
- OUTPUT_DATA holds its value until the next completion. buf may be overwritten freely meanwhile.
- Bubbles (input_valid=0) are allowed anywhere and leave all state unchanged.
- There is no backpressure. The downstream stage samples OUTPUT_DATA on the output_valid cycle.

## Timing
- Reset state: output_valid=0, output_drop=0, OUTPUT_DATA all 0, block_count=0, idx=0, buf all 0.
- Reset mid-block discards the partial block and does not pulse output_drop.
- Latency: output_valid is high exactly 1 cycle after the 64th accepted sample. output_drop is high 1 cycle after the realigning sample.
- Throughput: one block per 64 valid cycles. Back-to-back blocks need no gap cycle.
- output_valid and output_drop are each high for exactly one cycle per event. They are never high together.

## Configuration
- BLOCK_GATHER_CLIP_EN defined:
  - INPUT_DATA is treated as signed 32-bit and clamped before storage: values below 0 store 0, values above 1023 store 1023, others store unchanged.
  - The clamp adds no latency.
- BLOCK_GATHER_CLIP_EN undefined: samples are stored verbatim, all 32 bits.

## Test plan
- 64 consecutive valid samples with value = idx -> output_valid pulse on cycle 65, OUTPUT_DATA[r][c]=8r+c, block_count=1, output_drop never high.
- Same 64 samples with input_valid toggling every other cycle -> identical OUTPUT_DATA, single output_valid pulse 1 cycle after the last accepted sample.
- 128 back-to-back samples with value = 100+n -> pulses on cycles 65 and 129. OUTPUT_DATA[0][0]=100 between the pulses and 164 after the second. block_count=2.
- 20 samples, then input_first=1 with value 7, then 63 more samples -> output_drop pulse on cycle 22, then output_valid with OUTPUT_DATA[0][0]=7, block_count=1.
- RESET low for 1 cycle after 30 samples -> all outputs 0. A following full block completes correctly after exactly 64 samples with no output_drop.
- Samples 0xFFFFFFFF, 2000, 500 at indices 0..2 -> with BLOCK_GATHER_CLIP_EN: 0, 1023, 500. Without it: 0xFFFFFFFF, 2000, 500.

Source files
------------

// File: rtl/block_gather.sv
// Raster-to-block gatherer: collects 64 row-major samples into an 8x8 block and
// presents it on a registered array. Optional clamp via BLOCK_GATHER_CLIP_EN.
module block_gather #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          input_valid,
  input  logic                          input_first,
  input  logic [31:0]                   INPUT_DATA,
  output logic                          output_valid,
  output logic [7:0][7:0][31:0]         OUTPUT_DATA,
  output logic                          output_drop,
  output logic [COUNT_WIDTH-1:0]        block_count
);

  // state | meaning
  // EMPTY | idx==0, no partial block held
  // FILL  | idx 1..63, partial block in buf
  typedef enum logic {EMPTY, FILL} state_t;

  state_t                   r_state;
  logic [5:0]               r_idx;
  logic [7:0][7:0][31:0]    r_buf;
  logic [31:0]              w_sample;
  logic [7:0][7:0][31:0]    w_block;

`ifdef BLOCK_GATHER_CLIP_EN
  always_comb begin
    w_sample = INPUT_DATA;
    if ($signed(INPUT_DATA) < 32'sd0)
      w_sample = 32'd0;
    else if ($signed(INPUT_DATA) > 32'sd1023)
      w_sample = 32'd1023;
  end
`else
  always_comb begin
    w_sample = INPUT_DATA;
  end
`endif

  // The last sample bypasses buf so the block is complete on the same edge.
  always_comb begin
    w_block       = r_buf;
    w_block[7][7] = w_sample;
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_state      <= EMPTY;
      r_idx        <= 6'd0;
      r_buf        <= '0;
      OUTPUT_DATA  <= '0;
      output_valid <= 1'b0;
      output_drop  <= 1'b0;
      block_count  <= '0;
    end else begin
      output_valid <= 1'b0;
      output_drop  <= 1'b0;
      if (input_valid) begin
        if (input_first) begin
          r_buf[0][0] <= w_sample;
          r_idx       <= 6'd1;
          output_drop <= (r_state == FILL);
          r_state     <= FILL;
        end else begin
          r_buf[r_idx[5:3]][r_idx[2:0]] <= w_sample;
          if (r_idx == 6'd63) begin
            OUTPUT_DATA  <= w_block;
            output_valid <= 1'b1;
            block_count  <= block_count + COUNT_WIDTH'(1);
            r_idx        <= 6'd0;
            r_state      <= EMPTY;
          end else begin
            r_idx   <= r_idx + 6'd1;
            r_state <= FILL;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_block_gather.sv
// Directed self-checking bench for block_gather; expectations are hand-derived.
module tb_block_gather;

  logic                  CLOCK = 1'b0;
  logic                  RESET;
  logic                  input_valid;
  logic                  input_first;
  logic [31:0]           INPUT_DATA;
  logic                  output_valid;
  logic [7:0][7:0][31:0] OUTPUT_DATA;
  logic                  output_drop;
  logic [15:0]           block_count;

  int vecs  = 0;
  int fails = 0;

  block_gather #(.COUNT_WIDTH(16)) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .input_valid  (input_valid),
    .input_first  (input_first),
    .INPUT_DATA   (INPUT_DATA),
    .output_valid (output_valid),
    .OUTPUT_DATA  (OUTPUT_DATA),
    .output_drop  (output_drop),
    .block_count  (block_count)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one input cycle; outputs are sampled 1 time unit after the edge.
  task automatic send(input logic v, input logic f, input logic [31:0] d);
    input_valid = v;
    input_first = f;
    INPUT_DATA  = d;
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    RESET = 1'b0; input_valid = 1'b0; input_first = 1'b0; INPUT_DATA = 32'd0;
    repeat (2) @(posedge CLOCK);
    #1;
    check("rst_valid", 64'(output_valid), 64'd0);
    check("rst_drop",  64'(output_drop),  64'd0);
    check("rst_count", 64'(block_count),  64'd0);
    check("rst_data",  64'(OUTPUT_DATA == '0), 64'd1);
    RESET = 1'b1;

    // Block 1: value = idx, consecutive.
    for (int n = 0; n < 64; n++) begin
      send(1'b1, 1'b0, 32'(n));
      if (n < 63) check("b1_early_valid", 64'(output_valid), 64'd0);
      check("b1_drop", 64'(output_drop), 64'd0);
    end
    check("b1_valid", 64'(output_valid), 64'd1);
    check("b1_count", 64'(block_count), 64'd1);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        check("b1_data", 64'(OUTPUT_DATA[r][c]), 64'(8*r + c));
    send(1'b0, 1'b0, 32'd0);
    check("b1_pulse_width", 64'(output_valid), 64'd0);

    // Block 2: same values with bubbles; a bubble carrying input_first is ignored.
    for (int n = 0; n < 64; n++) begin
      send(1'b1, 1'b0, 32'(n));
      if (n < 63) begin
        check("b2_early_valid", 64'(output_valid), 64'd0);
        send(1'b0, (n == 30), 32'd999);
        check("b2_bubble_valid", 64'(output_valid), 64'd0);
        check("b2_bubble_drop", 64'(output_drop), 64'd0);
      end
    end
    check("b2_valid", 64'(output_valid), 64'd1);
    check("b2_count", 64'(block_count), 64'd2);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        check("b2_data", 64'(OUTPUT_DATA[r][c]), 64'(8*r + c));

    // Blocks 3,4 back to back: value = 100+n.
    for (int n = 0; n < 128; n++) begin
      send(1'b1, 1'b0, 32'(100 + n));
      if (n == 63) begin
        check("bb_valid1", 64'(output_valid), 64'd1);
        check("bb_first00", 64'(OUTPUT_DATA[0][0]), 64'd100);
        check("bb_first77", 64'(OUTPUT_DATA[7][7]), 64'd163);
        check("bb_count3", 64'(block_count), 64'd3);
      end else if (n > 63 && n < 127) begin
        check("bb_hold_valid", 64'(output_valid), 64'd0);
        check("bb_hold_data", 64'(OUTPUT_DATA[0][0]), 64'd100);
      end
    end
    check("bb_valid2", 64'(output_valid), 64'd1);
    check("bb_second00", 64'(OUTPUT_DATA[0][0]), 64'd164);
    check("bb_second77", 64'(OUTPUT_DATA[7][7]), 64'd227);
    check("bb_count4", 64'(block_count), 64'd4);

    // Realign mid-block: first from EMPTY gives no drop, from FILL gives one.
    for (int n = 0; n < 20; n++) begin
      send(1'b1, (n == 0), 32'(n));
      check("ra_nodrop", 64'(output_drop), 64'd0);
    end
    send(1'b1, 1'b1, 32'd7);
    check("ra_drop", 64'(output_drop), 64'd1);
    check("ra_drop_novalid", 64'(output_valid), 64'd0);
    for (int n = 0; n < 63; n++) begin
      send(1'b1, 1'b0, 32'(1000 + n));
      check("ra_drop_width", 64'(output_drop), 64'd0);
    end
    check("ra_valid", 64'(output_valid), 64'd1);
    check("ra_data00", 64'(OUTPUT_DATA[0][0]), 64'd7);
    check("ra_data01", 64'(OUTPUT_DATA[0][1]), 64'd1000);
    check("ra_data77", 64'(OUTPUT_DATA[7][7]), 64'd1062);
    check("ra_count", 64'(block_count), 64'd5);

    // input_first on the 64th sample drops instead of completing.
    for (int n = 0; n < 63; n++) send(1'b1, 1'b0, 32'(n));
    send(1'b1, 1'b1, 32'd42);
    check("p64_drop", 64'(output_drop), 64'd1);
    check("p64_novalid", 64'(output_valid), 64'd0);
    check("p64_count", 64'(block_count), 64'd5);
    check("p64_data_held", 64'(OUTPUT_DATA[0][0]), 64'd7);
    for (int n = 1; n < 64; n++) send(1'b1, 1'b0, 32'(n));
    check("p64_valid", 64'(output_valid), 64'd1);
    check("p64_data00", 64'(OUTPUT_DATA[0][0]), 64'd42);
    check("p64_count6", 64'(block_count), 64'd6);

    // Reset mid-block.
    for (int n = 0; n < 30; n++) send(1'b1, 1'b0, 32'(n));
    RESET = 1'b0;
    send(1'b0, 1'b0, 32'd0);
    check("mr_valid", 64'(output_valid), 64'd0);
    check("mr_drop",  64'(output_drop),  64'd0);
    check("mr_count", 64'(block_count),  64'd0);
    check("mr_data",  64'(OUTPUT_DATA == '0), 64'd1);
    RESET = 1'b1;
    for (int n = 0; n < 64; n++) begin
      send(1'b1, 1'b0, 32'(2*n));
      if (n < 63) check("mr_early_valid", 64'(output_valid), 64'd0);
      check("mr_nodrop", 64'(output_drop), 64'd0);
    end
    check("mr_valid_end", 64'(output_valid), 64'd1);
    check("mr_data00", 64'(OUTPUT_DATA[0][0]), 64'd0);
    check("mr_data35", 64'(OUTPUT_DATA[3][5]), 64'd58);
    check("mr_data77", 64'(OUTPUT_DATA[7][7]), 64'd126);
    check("mr_count1", 64'(block_count), 64'd1);

    // Clamp behaviour, including the bypassed last element.
    send(1'b1, 1'b0, 32'hFFFF_FFFF);
    send(1'b1, 1'b0, 32'd2000);
    send(1'b1, 1'b0, 32'd500);
    for (int n = 3; n < 63; n++) send(1'b1, 1'b0, 32'd0);
    send(1'b1, 1'b0, 32'd5000);
    check("cl_valid", 64'(output_valid), 64'd1);
`ifdef BLOCK_GATHER_CLIP_EN
    check("cl_neg",  64'(OUTPUT_DATA[0][0]), 64'd0);
    check("cl_high", 64'(OUTPUT_DATA[0][1]), 64'd1023);
    check("cl_last", 64'(OUTPUT_DATA[7][7]), 64'd1023);
`else
    check("cl_neg",  64'(OUTPUT_DATA[0][0]), 64'hFFFF_FFFF);
    check("cl_high", 64'(OUTPUT_DATA[0][1]), 64'd2000);
    check("cl_last", 64'(OUTPUT_DATA[7][7]), 64'd5000);
`endif
    check("cl_mid",   64'(OUTPUT_DATA[0][2]), 64'd500);
    check("cl_count", 64'(block_count), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
